// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter sharing one uart_tx between N_REQ requesters,
//            with a watchdog on the tx_busy handshake.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         ack,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     active,
    output logic                     timeout_err
);

    localparam int                c_IW       = $clog2(N_REQ);
    localparam int                c_CW       = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [c_IW-1:0]   c_LAST_RST = c_IW'(N_REQ - 1);
    localparam logic [c_IW:0]     c_NREQ     = (c_IW + 1)'(N_REQ);
    localparam logic [c_CW-1:0]   c_TIMEOUT  = c_CW'(BUSY_TIMEOUT);
    localparam logic [c_CW-1:0]   c_CNT_ONE  = c_CW'(1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_IW-1:0] r_last_grant;
    logic [c_IW-1:0] r_grant_id;
    logic [7:0]      r_tx_data;
    logic [c_CW-1:0] r_cnt;

    logic            w_sel_found;
    logic [c_IW-1:0] w_sel_idx;
    logic [c_IW:0]   w_cand;
    logic            w_grant;
    logic            w_timeout;

    // Walk offsets from farthest to nearest so the nearest pending index after
    // last_grant is the one left standing.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_cand      = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = {1'b0, r_last_grant} + (c_IW + 1)'(k);
            if (w_cand >= c_NREQ) begin
                w_cand = w_cand - c_NREQ;
            end
            if (req[w_cand[c_IW-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_cand[c_IW-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en && w_sel_found && !tx_busy) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_cnt >= c_TIMEOUT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_cnt holds the number of cycles elapsed since the ISSUE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_data    <= 8'h00;
            r_grant_id   <= '0;
            r_last_grant <= c_LAST_RST;
            r_cnt        <= '0;
        end else begin
            if (w_grant) begin
                r_tx_data  <= req_data[{w_sel_idx, 3'b000} +: 8];
                r_grant_id <= w_sel_idx;
            end
            if (r_state == S_ISSUE) begin
                r_last_grant <= r_grant_id;
                r_cnt        <= c_CNT_ONE;
            end else if (r_state == S_WAIT_BUSY) begin
                r_cnt        <= r_cnt + c_CNT_ONE;
            end else begin
                r_cnt        <= '0;
            end
        end
    end

    always_comb begin
        ack = '0;
        if (r_state == S_ISSUE) begin
            ack[r_grant_id] = 1'b1;
        end
    end

    assign tx_start    = (r_state == S_ISSUE);
    assign tx_data     = r_tx_data;
    assign grant_id    = r_grant_id;
    assign active      = (r_state != S_IDLE);
    assign timeout_err = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed self-checking bench for uart_tx_arbiter with a simple
//            uart_tx busy model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N_REQ        = 4;
    localparam int BUSY_TIMEOUT = 4;

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic [N_REQ-1:0]     req;
    logic [8*N_REQ-1:0]   req_data;
    logic [N_REQ-1:0]     ack;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic [1:0]           grant_id;
    logic                 active;
    logic                 timeout_err;

    logic model_busy;
    logic force_busy;
    logic model_on;
    int   busy_len;
    int   checks;
    int   errors;

    assign tx_busy = model_busy | force_busy;

    uart_tx_arbiter #(
        .N_REQ        (N_REQ),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // uart_tx stand-in: busy rises right after a start pulse, holds busy_len edges
    initial begin
        model_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (model_on && tx_start && !rst) begin
                model_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1;
                model_busy = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_start_seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (active === 1'b0) break;
        end
        chk({tag, "_idle"}, {31'd0, active}, 32'd0);
    endtask

    initial begin
        int k;
        int cnt;
        logic [1:0] exp_order [5];
        logic [7:0] exp_byte;

        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        en         = 1'b0;
        req        = '0;
        req_data   = '0;
        force_busy = 1'b0;
        model_on   = 1'b1;
        busy_len   = 3;

        // reset values
        repeat (3) tick();
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
        rst = 1'b0;

        // single requester 2
        req      = 4'b0100;
        req_data = 32'h00A5_0000;
        en       = 1'b1;
        tick();
        chk("single_tx_start", {31'd0, tx_start}, 32'd1);
        chk("single_ack", {28'd0, ack}, 32'h4);
        chk("single_tx_data", {24'd0, tx_data}, 32'hA5);
        chk("single_grant_id", {30'd0, grant_id}, 32'd2);
        chk("single_active", {31'd0, active}, 32'd1);
        req      = 4'b0000;
        req_data = 32'h0000_0000;
        tick();
        chk("single_ack_one_cycle", {28'd0, ack}, 32'd0);
        chk("single_start_one_cycle", {31'd0, tx_start}, 32'd0);
        wait_idle("single");
        chk("single_tx_data_hold", {24'd0, tx_data}, 32'hA5);

        // all requesters round-robin from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_order[0] = 2'd0;
        exp_order[1] = 2'd1;
        exp_order[2] = 2'd2;
        exp_order[3] = 2'd3;
        exp_order[4] = 2'd0;
        req      = 4'b1111;
        req_data = 32'h4433_2211;
        for (int g = 0; g < 5; g++) begin
            wait_start($sformatf("rr%0d", g));
            exp_byte = 8'h11 * (8'(exp_order[g]) + 8'd1);
            chk($sformatf("rr%0d_grant_id", g), {30'd0, grant_id}, {30'd0, exp_order[g]});
            chk($sformatf("rr%0d_ack", g), {28'd0, ack}, 32'd1 << exp_order[g]);
            chk($sformatf("rr%0d_tx_data", g), {24'd0, tx_data}, {24'd0, exp_byte});
        end
        req = 4'b0000;
        wait_idle("rr");

        // busy never rises: timeout after BUSY_TIMEOUT cycles
        model_on = 1'b0;
        req      = 4'b0001;
        req_data = 32'h0000_005A;
        wait_start("to");
        chk("to_ack", {28'd0, ack}, 32'h1);
        chk("to_grant_id", {30'd0, grant_id}, 32'd0);
        req = 4'b0000;
        k   = 0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            k++;
            if (ack !== 4'b0000) cnt++;
            if (timeout_err === 1'b1) break;
        end
        chk("to_pulse", {31'd0, timeout_err}, 32'd1);
        chk("to_latency", k, BUSY_TIMEOUT);
        chk("to_no_extra_ack", cnt, 32'd0);
        tick();
        chk("to_back_idle", {31'd0, active}, 32'd0);
        chk("to_pulse_one_cycle", {31'd0, timeout_err}, 32'd0);
        model_on = 1'b1;

        // reset during WAIT_DONE
        busy_len = 10;
        req      = 4'b0100;
        req_data = 32'h0077_0000;
        wait_start("mr");
        chk("mr_grant_id", {30'd0, grant_id}, 32'd2);
        req = 4'b0000;
        tick();
        tick();
        chk("mr_active_mid", {31'd0, active}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_async_active", {31'd0, active}, 32'd0);
        chk("mr_async_tx_data", {24'd0, tx_data}, 32'd0);
        chk("mr_async_grant_id", {30'd0, grant_id}, 32'd0);
        chk("mr_async_ack", {28'd0, ack}, 32'd0);
        chk("mr_async_tx_start", {31'd0, tx_start}, 32'd0);
        chk("mr_async_timeout", {31'd0, timeout_err}, 32'd0);
        repeat (12) tick();
        busy_len = 3;
        rst      = 1'b0;
        req      = 4'b1001;
        req_data = 32'hBB00_00CC;
        tick();
        chk("mr_first_edge_start", {31'd0, tx_start}, 32'd1);
        chk("mr_next_grant", {30'd0, grant_id}, 32'd0);
        chk("mr_next_data", {24'd0, tx_data}, 32'hCC);
        req = 4'b0000;
        wait_idle("mr");

        // en gating then withdrawal of requester 0
        en       = 1'b0;
        req      = 4'b0011;
        req_data = 32'h0000_2110;
        cnt      = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_start !== 1'b0) cnt++;
        end
        chk("en_gate_no_start", cnt, 32'd0);
        chk("en_gate_idle", {31'd0, active}, 32'd0);
        req = 4'b0010;
        en  = 1'b1;
        cnt = 0;
        wait_start("wd");
        chk("wd_grant_id", {30'd0, grant_id}, 32'd1);
        chk("wd_ack", {28'd0, ack}, 32'h2);
        chk("wd_tx_data", {24'd0, tx_data}, 32'h21);
        req = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack[0] !== 1'b0) cnt++;
        end
        chk("wd_no_ack0", cnt, 32'd0);
        chk("wd_idle", {31'd0, active}, 32'd0);

        // stale busy in IDLE blocks the grant
        force_busy = 1'b1;
        req        = 4'b0001;
        req_data   = 32'h0000_00E7;
        cnt        = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tx_start !== 1'b0) cnt++;
        end
        chk("busy_block_no_start", cnt, 32'd0);
        chk("busy_block_idle", {31'd0, active}, 32'd0);
        force_busy = 1'b0;
        tick();
        chk("busy_release_start", {31'd0, tx_start}, 32'd1);
        chk("busy_release_data", {24'd0, tx_data}, 32'hE7);

        // en dropped mid-transfer: transfer still completes
        req = 4'b0000;
        en  = 1'b0;
        wait_idle("en_mid");
        chk("en_mid_no_timeout", {31'd0, timeout_err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
